// File: rtl/naneye_cfg_pkg.sv
// Shared definitions for the NanEye configuration-window controller:
// FSM encoding and default geometry of the serial transfer.
package naneye_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } cfg_state_e;

    localparam int unsigned C_DEF_WORD_W  = 16;
    localparam int unsigned C_DEF_BIT_DIV = 36;
    localparam int unsigned C_DEF_CNT_W   = 8;

    // Bit counter must be able to hold C_WORD_W itself, hence the extra bit.
    function automatic int unsigned bit_cnt_w(input int unsigned word_w);
        return $clog2(word_w) + 1;
    endfunction

endpackage

// File: rtl/naneye_cfg_bitclk.sv
// Bit-period divider for the sensor serial link: produces the SCK phase
// and a strobe on the last cycle of every bit period.
module naneye_cfg_bitclk
    import naneye_cfg_pkg::*;
#(
    parameter int unsigned C_BIT_DIV = C_DEF_BIT_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic run_i,
    output logic bit_end_o,
    output logic sck_o
);

    localparam int unsigned        C_DIV_W = $clog2(C_BIT_DIV);
    localparam logic [C_DIV_W-1:0] C_LAST  = C_DIV_W'(C_BIT_DIV - 1);
    localparam logic [C_DIV_W-1:0] C_HALF  = C_DIV_W'(C_BIT_DIV / 2);

    logic [C_DIV_W-1:0] cnt_q;
    logic [C_DIV_W-1:0] cnt_d;
    logic               sck_q;
    logic               bit_end_q;

    // Next divider count: parked at zero whenever no bit is being shifted.
    always_comb begin
        cnt_d = '0;
        if (clr_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == C_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + C_DIV_W'(1);
        end
    end

    // Divider state; SCK and the strobe are registered alongside the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            sck_q     <= 1'b0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sck_q     <= (cnt_d >= C_HALF);
            bit_end_q <= (cnt_d == C_LAST);
        end
    end

    assign sck_o     = sck_q;
    assign bit_end_o = bit_end_q;

endmodule

// File: rtl/naneye_cfg_ctrl.sv
// Configuration-window sequencer: on each decoder request either shifts one
// pending host word to the sensor or acknowledges at once, then pulses CONFIG_DONE.
module naneye_cfg_ctrl
    import naneye_cfg_pkg::*;
#(
    parameter int unsigned C_WORD_W  = C_DEF_WORD_W,
    parameter int unsigned C_BIT_DIV = C_DEF_BIT_DIV,
    parameter int unsigned C_CNT_W   = C_DEF_CNT_W
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic [C_WORD_W-1:0] CFG_WDATA,
    input  logic                CFG_WE,
    input  logic                CONFIG_EN,
    output logic                CONFIG_DONE,
    output logic                CFG_PENDING,
    output logic                CFG_BUSY,
    output logic                SCK,
    output logic                SDA,
    output logic                SDA_OE,
    output logic [C_CNT_W-1:0]  CFG_COUNT
);

    localparam int unsigned     C_BW       = bit_cnt_w(C_WORD_W);
    localparam logic [C_BW-1:0] C_LAST_BIT = C_BW'(C_WORD_W - 1);

    cfg_state_e          state_q;
    logic [C_WORD_W-1:0] hold_q;
    logic [C_WORD_W-1:0] sr_q;
    logic                pending_q;
    logic [C_BW-1:0]     bit_q;
    logic [C_CNT_W-1:0]  cnt_q;
    logic                en_q;
    logic                en_prev_q;
    logic                done_q;
    logic                busy_q;
    logic                sda_q;
    logic                oe_q;

    logic                req_s;
    logic                start_s;
    logic [C_WORD_W-1:0] src_s;
    logic                run_s;
    logic                bit_end_s;
    logic                sck_s;

    // Request edge and transfer-start decision; a same-cycle write bypasses HOLD.
    always_comb begin
        req_s   = 1'b0;
        start_s = 1'b0;
        src_s   = hold_q;
        run_s   = (state_q == ST_SEND);
        if (CFG_WE) begin
            src_s = CFG_WDATA;
        end else begin
            src_s = hold_q;
        end
        if (state_q == ST_IDLE) begin
            req_s   = en_q && !en_prev_q;
            start_s = req_s && ENABLE && (pending_q || CFG_WE);
        end else begin
            req_s   = 1'b0;
            start_s = 1'b0;
        end
    end

    naneye_cfg_bitclk #(
        .C_BIT_DIV (C_BIT_DIV)
    ) u_bitclk (
        .clk_i     (CLOCK),
        .rst_ni    (RESET),
        .clr_i     (start_s),
        .run_i     (run_s),
        .bit_end_o (bit_end_s),
        .sck_o     (sck_s)
    );

    // Controller FSM with holding/shift registers and registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            sr_q      <= '0;
            pending_q <= 1'b0;
            bit_q     <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            en_prev_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sda_q     <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            en_q      <= CONFIG_EN;
            en_prev_q <= en_q;
            done_q    <= 1'b0;
            if (CFG_WE) begin
                hold_q    <= CFG_WDATA;
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        state_q   <= ST_SEND;
                        sr_q      <= src_s;
                        pending_q <= 1'b0;
                        bit_q     <= '0;
                        sda_q     <= src_s[C_WORD_W-1];
                        oe_q      <= 1'b1;
                        busy_q    <= 1'b1;
                    end else if (req_s) begin
                        state_q <= ST_ACK;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (bit_end_s && (bit_q == C_LAST_BIT)) begin
                        state_q <= ST_ACK;
                        done_q  <= 1'b1;
                        oe_q    <= 1'b0;
                        sda_q   <= 1'b0;
                        cnt_q   <= cnt_q + C_CNT_W'(1);
                    end else if (bit_end_s) begin
                        bit_q <= bit_q + C_BW'(1);
                        sr_q  <= {sr_q[C_WORD_W-2:0], 1'b0};
                        sda_q <= sr_q[C_WORD_W-2];
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    oe_q    <= 1'b0;
                    sda_q   <= 1'b0;
                end
            endcase
        end
    end

    assign CONFIG_DONE = done_q;
    assign CFG_PENDING = pending_q;
    assign CFG_BUSY    = busy_q;
    assign SCK         = sck_s;
    assign SDA         = sda_q;
    assign SDA_OE      = oe_q;
    assign CFG_COUNT   = cnt_q;

endmodule

// File: tb/tb_naneye_cfg_ctrl.sv
// Self-checking bench for naneye_cfg_ctrl: a vector table for the short paths,
// then hand-written frames, mid-transfer reset and counter wrap.
module tb_naneye_cfg_ctrl;

    logic        CLOCK;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] CFG_WDATA;
    logic        CFG_WE;
    logic        CONFIG_EN;
    logic        CONFIG_DONE;
    logic        CFG_PENDING;
    logic        CFG_BUSY;
    logic        SCK;
    logic        SDA;
    logic        SDA_OE;
    logic [7:0]  CFG_COUNT;

    logic        w_en, w_we, w_cen;
    logic [15:0] w_wdata;
    logic        w_done, w_pend, w_busy, w_sck, w_sda, w_oe;
    logic [7:0]  w_cnt;

    int n_cmp = 0;
    int n_err = 0;

    naneye_cfg_ctrl dut (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(ENABLE), .CFG_WDATA(CFG_WDATA),
        .CFG_WE(CFG_WE), .CONFIG_EN(CONFIG_EN), .CONFIG_DONE(CONFIG_DONE),
        .CFG_PENDING(CFG_PENDING), .CFG_BUSY(CFG_BUSY), .SCK(SCK), .SDA(SDA),
        .SDA_OE(SDA_OE), .CFG_COUNT(CFG_COUNT)
    );

    // Short bit period so 256 transfers fit comfortably in the run.
    naneye_cfg_ctrl #(.C_BIT_DIV(4)) u_wrap (
        .CLOCK(CLOCK), .RESET(RESET), .ENABLE(w_en), .CFG_WDATA(w_wdata),
        .CFG_WE(w_we), .CONFIG_EN(w_cen), .CONFIG_DONE(w_done),
        .CFG_PENDING(w_pend), .CFG_BUSY(w_busy), .SCK(w_sck), .SDA(w_sda),
        .SDA_OE(w_oe), .CFG_COUNT(w_cnt)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        en;
        logic        we;
        logic [15:0] wd;
        logic        cen;
        logic        done;
        logic        pend;
        logic        busy;
        logic        oe;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_req();
        CONFIG_EN = 1'b1;
        step();
    endtask

    task automatic idle_en();
        CONFIG_EN = 1'b0;
        step();
        step();
    endtask

    // Runs cycles E+1 .. E+577 of a transfer of word w, checking every cycle.
    task automatic run_frame(input logic [15:0] w, input int we_at, input logic [15:0] we_data,
                             input int tog_at, input int enoff_at);
        int          oe_bad  = 0;
        int          sda_bad = 0;
        int          sck_bad = 0;
        int          done_n  = 0;
        int          rises   = 0;
        logic        done_ok = 1'b0;
        logic [15:0] cap     = 16'h0000;
        logic        prev_sck;
        logic        exp_sck;
        logic        exp_sda;
        prev_sck = SCK;
        for (int n = 1; n <= 577; n++) begin
            CFG_WE = ((n - 1) == we_at);
            if (CFG_WE) CFG_WDATA = we_data;
            CONFIG_EN = ((n - 1) == tog_at) ? 1'b0 : 1'b1;
            if ((n - 1) == enoff_at) ENABLE = 1'b0;
            step();
            if (n == 1) chk("pending_at_start", {31'd0, CFG_PENDING}, 32'd0);
            exp_sck = (n <= 576) && (((n - 1) % 36) >= 18);
            exp_sda = (n <= 576) ? w[15 - ((n - 1) / 36)] : 1'b0;
            if (SDA_OE !== (n <= 576)) oe_bad++;
            if (SCK !== exp_sck) sck_bad++;
            if (SDA !== exp_sda) sda_bad++;
            if (SCK && !prev_sck) begin
                rises++;
                cap = {cap[14:0], SDA};
            end
            prev_sck = SCK;
            if (CONFIG_DONE) begin
                done_n++;
                if (n == 577) done_ok = 1'b1;
            end
        end
        CFG_WE = 1'b0;
        chk("oe_window_errs", oe_bad, 32'd0);
        chk("sck_phase_errs", sck_bad, 32'd0);
        chk("sda_bit_errs", sda_bad, 32'd0);
        chk("sck_rises", rises, 32'd16);
        chk("sampled_word", {16'd0, cap}, {16'd0, w});
        chk("done_pulses", done_n, 32'd1);
        chk("done_at_577", {31'd0, done_ok}, 32'd1);
        step();
        chk("done_after_ack", {31'd0, CONFIG_DONE}, 32'd0);
        chk("busy_after_ack", {31'd0, CFG_BUSY}, 32'd0);
    endtask

    initial begin
        int timeouts;
        int rst_done;

        //            en    we    wd        cen   done  pend  busy  oe
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 16'hA5C3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        RESET = 1'b0; ENABLE = 1'b1; CFG_WDATA = 16'h0000; CFG_WE = 1'b0; CONFIG_EN = 1'b0;
        w_en = 1'b1; w_we = 1'b0; w_cen = 1'b0; w_wdata = 16'h0000;
        step(); step(); step();
        chk("reset_outputs", {25'd0, CONFIG_DONE, CFG_PENDING, CFG_BUSY, SCK, SDA, SDA_OE, |CFG_COUNT}, 32'd0);
        chk("reset_count", {24'd0, CFG_COUNT}, 32'd0);
        RESET = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            ENABLE = vecs[i].en; CFG_WE = vecs[i].we; CFG_WDATA = vecs[i].wd; CONFIG_EN = vecs[i].cen;
            step();
            chk($sformatf("v%0d_done", i), {31'd0, CONFIG_DONE}, {31'd0, vecs[i].done});
            chk($sformatf("v%0d_pend", i), {31'd0, CFG_PENDING}, {31'd0, vecs[i].pend});
            chk($sformatf("v%0d_busy", i), {31'd0, CFG_BUSY}, {31'd0, vecs[i].busy});
            chk($sformatf("v%0d_oe", i), {31'd0, SDA_OE}, {31'd0, vecs[i].oe});
            chk($sformatf("v%0d_sck_sda", i), {30'd0, SCK, SDA}, 32'd0);
            chk($sformatf("v%0d_count", i), {24'd0, CFG_COUNT}, 32'd0);
        end
        CFG_WE = 1'b0;

        // Last write (A5C3) wins over BEEF and 1111.
        start_req();
        run_frame(16'hA5C3, -1, 16'h0000, -1, -1);
        chk("count_after_a5c3", {24'd0, CFG_COUNT}, 32'd1);
        chk("pend_after_a5c3", {31'd0, CFG_PENDING}, 32'd0);
        idle_en();

        // Write during SEND, plus an ignored request edge mid-frame.
        CFG_WDATA = 16'hFFFF; CFG_WE = 1'b1;
        step();
        CFG_WE = 1'b0;
        start_req();
        run_frame(16'hFFFF, 100, 16'h1234, 200, -1);
        chk("pend_after_ffff", {31'd0, CFG_PENDING}, 32'd1);
        chk("count_after_ffff", {24'd0, CFG_COUNT}, 32'd2);
        idle_en();

        // Deferred word goes out next window; ENABLE drops mid-frame.
        start_req();
        run_frame(16'h1234, -1, 16'h0000, -1, 50);
        chk("count_after_1234", {24'd0, CFG_COUNT}, 32'd3);
        chk("pend_after_1234", {31'd0, CFG_PENDING}, 32'd0);
        ENABLE = 1'b1;
        idle_en();

        // Write in the same cycle the request edge is seen: bypass path.
        start_req();
        run_frame(16'h00FF, 0, 16'h00FF, -1, -1);
        chk("count_after_00ff", {24'd0, CFG_COUNT}, 32'd4);
        chk("pend_after_00ff", {31'd0, CFG_PENDING}, 32'd0);
        idle_en();

        // Reset during bit 7 of a transfer.
        CFG_WDATA = 16'h5555; CFG_WE = 1'b1;
        step();
        CFG_WE = 1'b0;
        start_req();
        for (int n = 1; n <= 257; n++) step();
        chk("mid_frame_oe", {31'd0, SDA_OE}, 32'd1);
        RESET = 1'b0; CONFIG_EN = 1'b0;
        #2;
        chk("async_reset_outputs", {25'd0, CONFIG_DONE, CFG_PENDING, CFG_BUSY, SCK, SDA, SDA_OE, |CFG_COUNT}, 32'd0);
        rst_done = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (CONFIG_DONE) rst_done++;
        end
        chk("no_done_in_reset", rst_done, 32'd0);
        RESET = 1'b1;
        step();
        chk("post_reset_pend", {31'd0, CFG_PENDING}, 32'd0);
        chk("post_reset_count", {24'd0, CFG_COUNT}, 32'd0);
        chk("post_reset_busy", {31'd0, CFG_BUSY}, 32'd0);
        start_req();
        step();
        chk("post_reset_done_e1", {31'd0, CONFIG_DONE}, 32'd1);
        chk("post_reset_no_oe", {31'd0, SDA_OE}, 32'd0);
        step();
        chk("post_reset_done_e2", {31'd0, CONFIG_DONE}, 32'd0);
        idle_en();

        // 256 transfers on the short-period instance: counter wraps to zero.
        timeouts = 0;
        for (int i = 0; i < 256; i++) begin
            w_wdata = 16'(i); w_we = 1'b1; w_cen = 1'b1;
            step();
            w_we = 1'b0;
            for (int c = 0; c < 100 && !w_done; c++) step();
            if (!w_done) timeouts++;
            w_cen = 1'b0;
            step();
            step();
            if (i == 254) chk("count_255", {24'd0, w_cnt}, 32'd255);
        end
        chk("wrap_timeouts", timeouts, 32'd0);
        chk("count_wrapped", {24'd0, w_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/naneye_cfg_ctrl.md
# naneye_cfg_ctrl

- Sequences the sensor-configuration window of the NanEye receive path.
- Sits beside the RX decoder: on each decoder `CONFIG_EN` request it either serialises one pending host configuration word to the sensor or acknowledges immediately, then returns `CONFIG_DONE`.
- Replaces the bench-level one-cycle `CONFIG_DONE` echo with a real handshake.
- Runs in the 180 MHz sampling domain.

## Interface
Parameters:
- `C_WORD_W`, 16, configuration word width in bits.
- `C_BIT_DIV`, 36, CLOCK cycles per serial bit (180 MHz / 36 = 5 Mbit/s); even, ≥4.
- `C_CNT_W`, 8, width of the completed-transfer counter.

Ports:
- `CLOCK`  in  1  sampling clock; all logic on rising edge.
- `RESET`  in  1  asynchronous, active-low reset (0 = reset).
- `ENABLE`  in  1  1 = transfers allowed; 0 = every request acknowledged without transfer.
- `CFG_WDATA`  in  C_WORD_W  host configuration word.
- `CFG_WE`  in  1  one-cycle write strobe for `CFG_WDATA`.
- `CONFIG_EN`  in  1  request from decoder, level; rising edge starts a window.
- `CONFIG_DONE`  out  1  one-cycle acknowledge to decoder.
- `CFG_PENDING`  out  1  a written word awaits transmission.
- `CFG_BUSY`  out  1  state ≠ IDLE.
- `SCK`  out  1  serial bit clock to sensor.
- `SDA`  out  1  serial data, MSB first.
- `SDA_OE`  out  1  output enable for the bidirectional sensor line.
- `CFG_COUNT`  out  C_CNT_W  completed transfers, wraps.

## Operation
- Holding register HOLD (C_WORD_W) plus PENDING flag. `CFG_WE` loads HOLD and sets PENDING in any state.
- `CONFIG_EN` is registered; a request is a 0→1 transition seen in IDLE. Requests seen outside IDLE are ignored.
- States:
  - IDLE: on request with PENDING=1 and ENABLE=1 → SEND. Copy HOLD into shift register SR, clear PENDING. Otherwise a request → ACK.
  - SEND: shift C_WORD_W bits out of SR, then → ACK.
  - ACK: `CONFIG_DONE`=1 for exactly one cycle → IDLE. If SEND preceded it, CFG_COUNT increments, wrapping from 2^C_CNT_W−1 to 0.
- Request and `CFG_WE` in the same IDLE cycle: the new `CFG_WDATA` is sent (bypass) and PENDING is cleared.
- `CFG_WE` during SEND: HOLD updated, PENDING=1, word sent in the next window. SR is unaffected.
- Multiple writes before a window: last write wins.
- ENABLE falling during SEND: the transfer completes normally.
- Reset at any point: state IDLE, PENDING=0, HOLD=0, SR=0, CFG_COUNT=0. Any partial transfer is abandoned with no `CONFIG_DONE`.

## Timing
- Reset values: `CONFIG_DONE`=0, `CFG_PENDING`=0, `CFG_BUSY`=0, `SCK`=0, `SDA`=0, `SDA_OE`=0, `CFG_COUNT`=0.
- All outputs are registered.
- Edge registered at cycle E; state change at E+1.
- No-transfer path: `CONFIG_DONE`=1 at cycle E+1.
- Transfer path:
  - `SDA_OE`=1 from E+1 through E+C_WORD_W·C_BIT_DIV.
  - Bit k (k=0 is MSB) drives `SDA` during cycles E+1+k·C_BIT_DIV … E+(k+1)·C_BIT_DIV.
  - `SCK`=0 for the first C_BIT_DIV/2 cycles of each bit and 1 for the second half; the sensor samples on SCK rising.
  - `CONFIG_DONE`=1 and `SDA_OE`=0 at cycle E+C_WORD_W·C_BIT_DIV+1.
  - Default transfer latency is 577 cycles.
- `CFG_PENDING` falls at E+1 when a transfer starts. It rises the cycle after a `CFG_WE`.
- Outside SEND: `SCK`=0, `SDA`=0.

## Structure
- Shared package `naneye_cfg_pkg`:
  - state encoding (IDLE, SEND, ACK);
  - default constants C_WORD_W=16, C_BIT_DIV=36, C_CNT_W=8.
- One sub-module, `naneye_cfg_bitclk`:
  - bit-period divider counting 0…C_BIT_DIV−1;
  - outputs `BIT_END` strobe and `SCK` phase;
  - cleared by the controller at SEND entry.
- Top module holds the FSM, HOLD/SR, bit counter (⌈log2 C_WORD_W⌉+1 bits) and CFG_COUNT.

## Test plan
- No pending word, ENABLE=1, `CONFIG_EN` 0→1 → `CONFIG_DONE` pulse at E+1; SDA_OE stays 0; CFG_COUNT stays 0.
- Write 0xA5C3, then request → SDA_OE high 576 cycles; 16 SCK rising edges sample 1010010111000011; CONFIG_DONE at E+577; CFG_COUNT=1; CFG_PENDING=0.
- Write 0x1234 during a SEND of 0xFFFF → current frame stays all ones; CFG_PENDING=1 afterwards; next request sends 0x1234.
- `CFG_WE`=0x00FF in the same cycle as the request edge → 0x00FF transmitted; CFG_PENDING=0 at E+1.
- ENABLE=0 with pending 0xBEEF → CONFIG_DONE at E+1, no SDA_OE, CFG_PENDING remains 1.
- Assert RESET=0 at bit 7 of a transfer → all outputs at reset values asynchronously; no CONFIG_DONE. After release, a new request with no write acknowledges at E+1. Also run 256 transfers → CFG_COUNT wraps to 0.
